// File: rtl/kgp_multicycle_ctrl.sv
// kgp_multicycle_ctrl
// Multi-cycle sequencer for the KGP RISC datapath. Each instruction steps
// through FETCH/DECODE/EXEC/MEM/WB because both memories are 1-cycle BRAMs.
// It also holds the architectural carry flag that bcy/bncy branch on.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   hold                      freeze state/carry, suppress write enables
//   opcode, funccode          instr[31:27], instr[4:0]
//   carryFlag/zeroFlag/negFlag ALU status inputs
//   irWrite, pcWrite, pcSrc   IR/PC control
//   ALUResOp, ALUSrc, ALUFrc  ALU control
//   brLink, memToReg, memRead, memWrite, regWrite  datapath strobes
//   carryReg, halted, state   status
//
// state | meaning
// 000   | FETCH  - imem addressed by PC
// 001   | DECODE - IR loaded, opcode decoded
// 010   | EXEC   - ALU operation / branch resolution
// 011   | MEM    - dmem access (lw/sw)
// 100   | WB     - register write-back, PC+4
// 101   | HALT   - stopped until reset
module kgp_multicycle_ctrl #(
  parameter logic [4:0] HALT_OPC    = 5'b11111,
  parameter bit         ILLEGAL_NOP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic [4:0] opcode,
  input  logic [4:0] funccode,
  input  logic       carryFlag,
  input  logic       zeroFlag,
  input  logic       negFlag,
  output logic       irWrite,
  output logic       pcWrite,
  output logic [1:0] pcSrc,
  output logic [2:0] ALUResOp,
  output logic [1:0] ALUSrc,
  output logic       ALUFrc,
  output logic       brLink,
  output logic       memToReg,
  output logic       memRead,
  output logic       memWrite,
  output logic       regWrite,
  output logic       carryReg,
  output logic       halted,
  output logic [2:0] state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [4:0] OP_RR    = 5'd0;
  localparam logic [4:0] OP_ADDI  = 5'd1;
  localparam logic [4:0] OP_COMPI = 5'd2;
  localparam logic [4:0] OP_LW    = 5'd3;
  localparam logic [4:0] OP_SW    = 5'd4;
  localparam logic [4:0] OP_B     = 5'd5;
  localparam logic [4:0] OP_BL    = 5'd6;
  localparam logic [4:0] OP_BCY   = 5'd7;
  localparam logic [4:0] OP_BNCY  = 5'd8;
  localparam logic [4:0] OP_BR    = 5'd9;
  localparam logic [4:0] OP_BLTZ  = 5'd10;
  localparam logic [4:0] OP_BZ    = 5'd11;
  localparam logic [4:0] OP_BNZ   = 5'd12;

  localparam logic [4:0] FN_ADD   = 5'd0;
  localparam logic [4:0] FN_COMP  = 5'd1;
  localparam logic [4:0] FN_AND   = 5'd2;
  localparam logic [4:0] FN_XOR   = 5'd3;
  localparam logic [4:0] FN_SHLL  = 5'd4;
  localparam logic [4:0] FN_SHRL  = 5'd5;
  localparam logic [4:0] FN_SHLLV = 5'd6;
  localparam logic [4:0] FN_SHRLV = 5'd7;
  localparam logic [4:0] FN_SHRA  = 5'd8;
  localparam logic [4:0] FN_SHRAV = 5'd9;

  logic [2:0] state_next;
  logic       is_halt;
  logic       opc_legal;
  logic       func_legal;
  logic       carry_upd;
  logic       pc_we;
  logic       ir_we;
  logic       reg_we;
  logic       mem_we;

  // HALT_OPC wins over the legal map in case it is parameterised onto one
  always_comb begin
    is_halt    = (opcode == HALT_OPC);
    opc_legal  = (opcode <= OP_BNZ);
    func_legal = (funccode <= FN_SHRAV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      carryReg <= 1'b0;
    end else begin
      state <= state_next;
      if (carry_upd) carryReg <= carryFlag;
    end
  end

  always_comb begin
    state_next = state;
    if (!hold) begin
      case (state)
        S_FETCH:  state_next = S_DECODE;
        S_DECODE: begin
          if (is_halt)        state_next = S_HALT;
          else if (opc_legal) state_next = S_EXEC;
          else if (ILLEGAL_NOP) state_next = S_FETCH;
          else                state_next = S_HALT;
        end
        S_EXEC: begin
          case (opcode)
            OP_RR: begin
              if (func_legal)       state_next = S_WB;
              else if (ILLEGAL_NOP) state_next = S_FETCH;
              else                  state_next = S_HALT;
            end
            OP_ADDI, OP_COMPI: state_next = S_WB;
            OP_LW, OP_SW:      state_next = S_MEM;
            default:           state_next = S_FETCH;
          endcase
        end
        S_MEM:    state_next = (opcode == OP_LW) ? S_WB : S_FETCH;
        S_WB:     state_next = S_FETCH;
        S_HALT:   state_next = S_HALT;
        default:  state_next = S_FETCH;
      endcase
    end
  end

  always_comb begin
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    pcSrc     = 2'b00;
    ALUResOp  = 3'b000;
    ALUSrc    = 2'b00;
    ALUFrc    = 1'b0;
    brLink    = 1'b0;
    memToReg  = 1'b0;
    memRead   = 1'b0;
    halted    = 1'b0;
    carry_upd = 1'b0;
    case (state)
      S_DECODE: begin
        ir_we = 1'b1;
        // illegal opcode retiring as a NOP: PC+4 straight from DECODE
        if (!is_halt && !opc_legal && ILLEGAL_NOP) pc_we = 1'b1;
      end
      S_EXEC: begin
        case (opcode)
          OP_RR: begin
            if (func_legal) begin
              carry_upd = (funccode == FN_ADD) || (funccode == FN_COMP);
              case (funccode)
                FN_COMP:            ALUResOp = 3'b001;
                FN_AND:             ALUResOp = 3'b010;
                FN_XOR:             ALUResOp = 3'b011;
                FN_SHLL, FN_SHLLV:  ALUResOp = 3'b100;
                FN_SHRL, FN_SHRLV:  ALUResOp = 3'b101;
                FN_SHRA, FN_SHRAV:  ALUResOp = 3'b110;
                default:            ALUResOp = 3'b000;
              endcase
              if (funccode == FN_SHLL || funccode == FN_SHRL || funccode == FN_SHRA)
                ALUSrc = 2'b10;
            end else if (ILLEGAL_NOP) begin
              pc_we = 1'b1;
            end
          end
          OP_ADDI: begin
            ALUSrc    = 2'b01;
            carry_upd = 1'b1;
          end
          OP_COMPI: begin
            ALUSrc    = 2'b01;
            ALUResOp  = 3'b001;
            carry_upd = 1'b1;
          end
          OP_LW, OP_SW: begin
            ALUFrc = 1'b1;
            ALUSrc = 2'b01;
          end
          OP_B: begin
            pc_we = 1'b1;
            pcSrc = 2'b01;
          end
          OP_BL: begin
            pc_we  = 1'b1;
            pcSrc  = 2'b01;
            reg_we = 1'b1;
            brLink = 1'b1;
          end
          OP_BCY: begin
            pc_we = 1'b1;
            pcSrc = carryReg ? 2'b01 : 2'b00;
          end
          OP_BNCY: begin
            pc_we = 1'b1;
            pcSrc = carryReg ? 2'b00 : 2'b01;
          end
          OP_BR: begin
            pc_we = 1'b1;
            pcSrc = 2'b10;
          end
          OP_BLTZ: begin
            pc_we  = 1'b1;
            ALUSrc = 2'b11;
            pcSrc  = negFlag ? 2'b01 : 2'b00;
          end
          OP_BZ: begin
            pc_we  = 1'b1;
            ALUSrc = 2'b11;
            pcSrc  = zeroFlag ? 2'b01 : 2'b00;
          end
          OP_BNZ: begin
            pc_we  = 1'b1;
            ALUSrc = 2'b11;
            pcSrc  = zeroFlag ? 2'b00 : 2'b01;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (opcode == OP_LW) begin
          memRead = 1'b1;
        end else begin
          mem_we = 1'b1;
          pc_we  = 1'b1;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        if (opcode == OP_LW) begin
          memRead  = 1'b1;
          memToReg = 1'b1;
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    // hold suppresses every architectural write; the state is frozen by the
    // next-state logic so the suppressed strobe is reissued after release
    if (hold) carry_upd = 1'b0;
  end

  assign irWrite  = ir_we  & ~hold;
  assign pcWrite  = pc_we  & ~hold;
  assign regWrite = reg_we & ~hold;
  assign memWrite = mem_we & ~hold;

endmodule

// File: tb/tb_kgp_multicycle_ctrl.sv
module tb_kgp_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       rst, hold;
  logic [4:0] opcode, funccode;
  logic       carryFlag, zeroFlag, negFlag;
  logic       irWrite, pcWrite, ALUFrc, brLink, memToReg, memRead, memWrite, regWrite;
  logic       carryReg, halted;
  logic [1:0] pcSrc, ALUSrc;
  logic [2:0] ALUResOp, state;

  kgp_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .hold(hold), .opcode(opcode), .funccode(funccode),
    .carryFlag(carryFlag), .zeroFlag(zeroFlag), .negFlag(negFlag),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .ALUResOp(ALUResOp),
    .ALUSrc(ALUSrc), .ALUFrc(ALUFrc), .brLink(brLink), .memToReg(memToReg),
    .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
    .carryReg(carryReg), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic model_carry = 1'b0;

  // instruction classes
  localparam int K_RR = 0, K_IMM = 1, K_LW = 2, K_SW = 3, K_BR = 4,
                 K_HALT = 5, K_ILL = 6, K_BADF = 7;

  // reg-reg funccode -> expected ALU operation (add,comp,and,xor,sll,srl,sll,srl,sra,sra)
  logic [2:0] rr_op [0:9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd5, 3'd6, 3'd6};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] strobes();
    return {irWrite, pcWrite, regWrite, memRead, memWrite, memToReg, brLink, ALUFrc, halted};
  endfunction

  task automatic run_instr(input logic [4:0] opc, input logic [4:0] fc,
                           input logic cf, input logic zf, input logic nf,
                           input int hold_exec, input bit hold_rand);
    int kind;
    logic [2:0] seq[$];
    int idx = 0, held = 0, guard = 0;
    logic [2:0] ph;
    bit h, last, taken, e_ir, e_pc, e_reg, e_mr, e_mw, e_m2r, e_brl, e_frc, e_hlt;
    logic [1:0] e_src;

    if (opc == 5'd31)      kind = K_HALT;
    else if (opc > 5'd12)  kind = K_ILL;
    else if (opc == 5'd0)  kind = (fc <= 5'd9) ? K_RR : K_BADF;
    else if (opc <= 5'd2)  kind = K_IMM;
    else if (opc == 5'd3)  kind = K_LW;
    else if (opc == 5'd4)  kind = K_SW;
    else                   kind = K_BR;

    seq.push_back(3'd0);
    seq.push_back(3'd1);
    case (kind)
      K_RR, K_IMM: begin seq.push_back(3'd2); seq.push_back(3'd4); end
      K_LW:   begin seq.push_back(3'd2); seq.push_back(3'd3); seq.push_back(3'd4); end
      K_SW:   begin seq.push_back(3'd2); seq.push_back(3'd3); end
      K_BR, K_BADF: seq.push_back(3'd2);
      K_HALT: seq.push_back(3'd5);
      default: ;
    endcase

    case (opc)
      5'd5, 5'd6: taken = 1'b1;
      5'd7:  taken = model_carry;
      5'd8:  taken = !model_carry;
      5'd10: taken = nf;
      5'd11: taken = zf;
      5'd12: taken = !zf;
      default: taken = 1'b0;
    endcase

    opcode = opc; funccode = fc; carryFlag = cf; zeroFlag = zf; negFlag = nf;
    while (idx < seq.size()) begin
      ph = seq[idx];
      h  = 1'b0;
      if (ph == 3'd2 && held < hold_exec) begin h = 1'b1; held++; end
      else if (hold_rand && $urandom_range(0, 5) == 0) h = 1'b1;
      hold = h;
      #1;
      last  = (idx == seq.size() - 1);
      e_ir  = (ph == 3'd1);
      e_pc  = last && kind != K_HALT;
      e_reg = (ph == 3'd4) || (ph == 3'd2 && opc == 5'd6);
      e_mr  = kind == K_LW && (ph == 3'd3 || ph == 3'd4);
      e_mw  = kind == K_SW && ph == 3'd3;
      e_m2r = kind == K_LW && ph == 3'd4;
      e_brl = opc == 5'd6 && ph == 3'd2;
      e_frc = (kind == K_LW || kind == K_SW) && ph == 3'd2;
      e_hlt = (ph == 3'd5);
      chk("state", state, ph);
      chk("carryReg", carryReg, model_carry);
      if (e_pc) begin
        e_src = (kind == K_BR) ? ((opc == 5'd9) ? 2'b10 : (taken ? 2'b01 : 2'b00)) : 2'b00;
        chk("pcSrc", pcSrc, e_src);
      end
      if (h) begin e_ir = 0; e_pc = 0; e_reg = 0; e_mw = 0; end
      chk("strobes", strobes(),
          {e_ir, e_pc, e_reg, e_mr, e_mw, e_m2r, e_brl, e_frc, e_hlt});
      if (ph == 3'd2) begin
        case (kind)
          K_RR: begin
            chk("ALUResOp_rr", ALUResOp, rr_op[fc]);
            chk("ALUSrc_rr", ALUSrc, (fc == 5'd4 || fc == 5'd5 || fc == 5'd8) ? 2'b10 : 2'b00);
          end
          K_IMM: begin
            chk("ALUResOp_imm", ALUResOp, (opc == 5'd1) ? 3'd0 : 3'd1);
            chk("ALUSrc_imm", ALUSrc, 2'b01);
          end
          K_LW, K_SW: begin
            chk("ALUResOp_mem", ALUResOp, 3'd0);
            chk("ALUSrc_mem", ALUSrc, 2'b01);
          end
          K_BR: if (opc >= 5'd10) begin
            chk("ALUResOp_br", ALUResOp, 3'd0);
            chk("ALUSrc_br", ALUSrc, 2'b11);
          end
          default: ;
        endcase
      end
      @(posedge clk); #1;
      if (!h) begin
        if (ph == 3'd2 && ((kind == K_RR && fc <= 5'd1) || kind == K_IMM)) model_carry = cf;
        idx++;
      end
      guard++;
      if (guard > 200) begin
        n_checks++; n_fail++;
        $display("FAIL cycle_budget opcode=%0d observed_state=%0d", opc, state);
        break;
      end
    end
    hold = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] ro, rf;
    rst = 1'b1; hold = 1'b1; opcode = 5'b10101; funccode = 5'd0;
    carryFlag = 1'b1; zeroFlag = 1'b0; negFlag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", state, 3'd0);
    chk("reset_carry", carryReg, 1'b0);
    chk("reset_strobes", {strobes(), pcSrc}, 11'd0);
    rst = 1'b0; hold = 1'b0;
    model_carry = 1'b0;

    run_instr(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);   // add
    run_instr(5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);   // lw
    run_instr(5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);   // sw
    run_instr(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 0, 0);   // addi, carry=1
    run_instr(5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);   // bcy taken
    run_instr(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);   // bncy not taken
    run_instr(5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);   // addi, carry=0
    run_instr(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 0, 0);   // bcy not taken
    run_instr(5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);   // bl
    run_instr(5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);   // br
    run_instr(5'd11, 5'd0, 1'b0, 1'b1, 1'b0, 0, 0);  // bz taken
    run_instr(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3, 0);   // add with 3-cycle hold in EXEC
    run_instr(5'd20, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);  // illegal opcode -> NOP
    run_instr(5'd0, 5'd15, 1'b1, 1'b0, 1'b0, 0, 0);  // bad funccode -> NOP

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) ro = 5'($urandom_range(13, 30));
      else                           ro = 5'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) rf = 5'($urandom_range(10, 31));
      else                           rf = 5'($urandom_range(0, 9));
      run_instr(ro, rf, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 0, 1);
    end

    run_instr(5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 0, 0);  // halt
    for (int i = 0; i < 20; i++) begin
      opcode = 5'($urandom_range(0, 31)); funccode = 5'($urandom_range(0, 31));
      hold = 1'($urandom_range(0, 1)); carryFlag = 1'($urandom_range(0, 1));
      #1;
      chk("halt_state", state, 3'd5);
      chk("halt_strobes", strobes(), 9'b0_0000_0001);
      @(posedge clk); #1;
    end
    hold = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_from_halt_state", state, 3'd0);
    chk("rst_from_halt_strobes", {strobes(), carryReg}, 10'd0);
    rst = 1'b0;
    model_carry = 1'b0;
    run_instr(5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 0, 0);   // compi after reset

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
